// File: rtl/roic_readout_scheduler.sv
// ----------------------------------------------------------------------------
// roic_readout_scheduler
// Reads out one line from the ROIC deserializer channels. Each enabled
// channel is visited in ascending order, one channel at a time. For each
// channel the block waits for that channel to be ready, then requests it and
// forwards its words as a single tagged output stream. A channel that never
// becomes ready is skipped after a timeout.
//
// Ports
//   data_read_clk      read clock; all logic runs on its rising edge
//   deser_reset_n      asynchronous active-low reset
//   line_start         single-cycle pulse that starts one line readout
//   ch_enable_mask     channels included in the line, sampled at line start
//   valid_read_enable  per-channel ready-to-read
//   reordered_data_a/b per-channel data words
//   reordered_valid    per-channel data valid
//   data_read_req      one-hot (or zero) read request to the channel array
//   out_data_a/b       registered output words
//   out_valid          output word valid
//   out_ch             channel index of the output word
//   out_first/out_last first/last word of a channel burst
//   busy               line in progress
//   line_done          one-cycle end-of-line pulse
//   timeout_mask       channels skipped by timeout in the current line
//   overrun            sticky: line_start seen while busy
// ----------------------------------------------------------------------------
module roic_readout_scheduler #(
    parameter int unsigned NUM_CH       = 12,
    parameter int unsigned WORDS_PER_CH = 256,
    parameter int unsigned TIMEOUT_CYC  = 4096,
    parameter int unsigned GAP_CYC      = 2
) (
    input  logic                 data_read_clk,
    input  logic                 deser_reset_n,
    input  logic                 line_start,
    input  logic [NUM_CH-1:0]    ch_enable_mask,
    input  logic [NUM_CH-1:0]    valid_read_enable,
    input  logic [23:0]          reordered_data_a [NUM_CH-1:0],
    input  logic [23:0]          reordered_data_b [NUM_CH-1:0],
    input  logic [NUM_CH-1:0]    reordered_valid,
    output logic [NUM_CH-1:0]    data_read_req,
    output logic [23:0]          out_data_a,
    output logic [23:0]          out_data_b,
    output logic                 out_valid,
    output logic [3:0]           out_ch,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 busy,
    output logic                 line_done,
    output logic [NUM_CH-1:0]    timeout_mask,
    output logic                 overrun
);

    localparam int unsigned CH_W  = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned GAP_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_WAIT,
        S_READ,
        S_GAP,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [NUM_CH-1:0]  r_lmask;
    logic [CH_W-1:0]    r_ch_ptr;
    logic [CH_W-1:0]    r_cur_ch;
    logic [CNT_W-1:0]   r_tcnt;
    logic [CNT_W-1:0]   r_wcnt;
    logic [GAP_W-1:0]   r_gcnt;

    logic               w_found;
    logic [CH_W-1:0]    w_sel;
    logic               w_vre_cur;
    logic               w_rv_cur;
    logic               w_last;
    logic [23:0]        w_da_cur;
    logic [23:0]        w_db_cur;

    // Lowest enabled channel at or above the channel pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (r_lmask[i] && (CH_W'(i) >= r_ch_ptr)) begin
                w_found = 1'b1;
                w_sel   = CH_W'(i);
            end
        end
    end

    // Selected-channel views; other channels are ignored.
    assign w_vre_cur = valid_read_enable[r_cur_ch];
    assign w_rv_cur  = reordered_valid[r_cur_ch];
    assign w_da_cur  = reordered_data_a[r_cur_ch];
    assign w_db_cur  = reordered_data_b[r_cur_ch];
    assign w_last    = (r_wcnt == CNT_W'(WORDS_PER_CH - 1));

    // Sequencer with registered outputs.
    always_ff @(posedge data_read_clk or negedge deser_reset_n) begin
        if (!deser_reset_n) begin
            r_state       <= S_IDLE;
            r_lmask       <= '0;
            r_ch_ptr      <= '0;
            r_cur_ch      <= '0;
            r_tcnt        <= '0;
            r_wcnt        <= '0;
            r_gcnt        <= '0;
            data_read_req <= '0;
            out_data_a    <= '0;
            out_data_b    <= '0;
            out_valid     <= 1'b0;
            out_ch        <= '0;
            out_first     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            line_done     <= 1'b0;
            timeout_mask  <= '0;
            overrun       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            line_done <= 1'b0;

            // Any line_start outside IDLE (DONE included) is lost.
            if (line_start && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (line_start) begin
                        r_lmask      <= ch_enable_mask;
                        timeout_mask <= '0;
                        busy         <= 1'b1;
                        r_ch_ptr     <= '0;
                        r_state      <= S_SEL;
                    end
                end

                S_SEL: begin
                    if (w_found) begin
                        r_cur_ch <= w_sel;
                        r_tcnt   <= '0;
                        r_state  <= S_WAIT;
                    end else begin
                        line_done <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                S_WAIT: begin
                    if (w_vre_cur) begin
                        data_read_req <= NUM_CH'(1) << r_cur_ch;
                        r_wcnt        <= '0;
                        r_state       <= S_READ;
                    end else if (r_tcnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        timeout_mask[r_cur_ch] <= 1'b1;
                        r_ch_ptr               <= r_cur_ch + CH_W'(1);
                        r_state                <= S_SEL;
                    end else begin
                        r_tcnt <= r_tcnt + CNT_W'(1);
                    end
                end

                S_READ: begin
                    if (w_rv_cur) begin
                        out_data_a <= w_da_cur;
                        out_data_b <= w_db_cur;
                        out_valid  <= 1'b1;
                        out_ch     <= r_cur_ch;
                        out_first  <= (r_wcnt == '0);
                        out_last   <= w_last;
                        r_wcnt     <= r_wcnt + CNT_W'(1);
                        if (w_last) begin
                            data_read_req <= '0;
                            r_ch_ptr      <= r_cur_ch + CH_W'(1);
                            r_gcnt        <= '0;
                            r_state       <= (GAP_CYC == 0) ? S_SEL : S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (r_gcnt == GAP_W'(GAP_CYC - 1)) begin
                        r_state <= S_SEL;
                    end else begin
                        r_gcnt <= r_gcnt + GAP_W'(1);
                    end
                end

                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // At most one channel is ever requested.
    a_req_onehot0: assert property (@(posedge data_read_clk) disable iff (!deser_reset_n)
        $onehot0(data_read_req));

endmodule

// File: tb/tb_roic_readout_scheduler.sv
// ----------------------------------------------------------------------------
// Bench for roic_readout_scheduler. A channel-array emulator answers read
// requests with words from per-line random tables. At line start the expected
// output stream is built from the mask and the set of dead channels, and a
// monitor pops and compares every out_valid word.
// ----------------------------------------------------------------------------
module tb_roic_readout_scheduler;

    localparam int unsigned NCH = 12;
    localparam int unsigned WPC = 4;
    localparam int unsigned TMO = 16;
    localparam int unsigned GAP = 2;

    logic            clk;
    logic            rst_n;
    logic            line_start;
    logic [NCH-1:0]  mask;
    logic [NCH-1:0]  vre;
    logic [23:0]     da [NCH-1:0];
    logic [23:0]     db [NCH-1:0];
    logic [NCH-1:0]  rvalid;
    logic [NCH-1:0]  req;
    logic [23:0]     out_a;
    logic [23:0]     out_b;
    logic            out_valid;
    logic [3:0]      out_ch;
    logic            out_first;
    logic            out_last;
    logic            busy;
    logic            line_done;
    logic [NCH-1:0]  tmo_mask;
    logic            overrun;

    roic_readout_scheduler #(
        .NUM_CH       (NCH),
        .WORDS_PER_CH (WPC),
        .TIMEOUT_CYC  (TMO),
        .GAP_CYC      (GAP)
    ) dut (
        .data_read_clk     (clk),
        .deser_reset_n     (rst_n),
        .line_start        (line_start),
        .ch_enable_mask    (mask),
        .valid_read_enable (vre),
        .reordered_data_a  (da),
        .reordered_data_b  (db),
        .reordered_valid   (rvalid),
        .data_read_req     (req),
        .out_data_a        (out_a),
        .out_data_b        (out_b),
        .out_valid         (out_valid),
        .out_ch            (out_ch),
        .out_first         (out_first),
        .out_last          (out_last),
        .busy              (busy),
        .line_done         (line_done),
        .timeout_mask      (tmo_mask),
        .overrun           (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [3:0]  ch;
        logic        first;
        logic        last;
    } exp_t;

    exp_t           exp_q[$];
    logic [23:0]    tbl_a [NCH][WPC];
    logic [23:0]    tbl_b [NCH][WPC];
    int             sent [NCH];
    logic [NCH-1:0] cur_mask;
    logic [NCH-1:0] dead_mask;
    bit             vre_rand;
    bit             strict_gap;
    int             n_vec;
    int             n_err;
    int             done_cnt;
    bit             seen;
    int             low_run;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Channel array emulator: ready, and data only while requested.
    always @(negedge clk) begin
        for (int c = 0; c < int'(NCH); c++) begin
            vre[c] = dead_mask[c] ? 1'b0 : (vre_rand ? ($urandom_range(3) != 0) : 1'b1);
            if (!req[c]) begin
                sent[c]   = 0;
                rvalid[c] = 1'($urandom_range(1));
                da[c]     = 24'($urandom);
                db[c]     = 24'($urandom);
            end else if (sent[c] < int'(WPC) && $urandom_range(3) != 0) begin
                rvalid[c] = 1'b1;
                da[c]     = tbl_a[c][sent[c]];
                db[c]     = tbl_b[c][sent[c]];
                sent[c]   = sent[c] + 1;
            end else begin
                rvalid[c] = 1'b0;
                da[c]     = 24'($urandom);
                db[c]     = 24'($urandom);
            end
        end
    end

    // Output monitor and request legality.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got ch %0d data %0h with empty queue", out_ch, out_a);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", {10'd0, out_ch, out_first, out_last, out_a, out_b},
                        {10'd0, e.ch, e.first, e.last, e.a, e.b});
                end
            end
            chk("req_legal", {51'd0, $onehot0(req), req & ~cur_mask}, {51'd0, 1'b1, 12'h000});
            if (line_done) done_cnt++;
            if (req != '0) begin
                if (seen && strict_gap && low_run > 0)
                    chk("gap_len", 64'(low_run), 64'(GAP + 2));
                seen    = 1'b1;
                low_run = 0;
            end else if (seen) begin
                low_run++;
            end
        end
    end

    task automatic start_line(input logic [NCH-1:0] m, input logic [NCH-1:0] dead);
        exp_t e;
        cur_mask  = m;
        dead_mask = dead;
        done_cnt  = 0;
        seen      = 1'b0;
        low_run   = 0;
        for (int c = 0; c < int'(NCH); c++) begin
            for (int k = 0; k < int'(WPC); k++) begin
                tbl_a[c][k] = 24'($urandom);
                tbl_b[c][k] = 24'($urandom);
            end
        end
        for (int c = 0; c < int'(NCH); c++) begin
            if (m[c] && !dead[c]) begin
                for (int k = 0; k < int'(WPC); k++) begin
                    e.a     = tbl_a[c][k];
                    e.b     = tbl_b[c][k];
                    e.ch    = 4'(c);
                    e.first = (k == 0);
                    e.last  = (k == int'(WPC) - 1);
                    exp_q.push_back(e);
                end
            end
        end
        @(negedge clk);
        mask       = m;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        mask       = NCH'($urandom);
    endtask

    // Waits for line_done; lat counts cycles from the line_start cycle.
    task automatic finish_line(input logic [NCH-1:0] m, input logic [NCH-1:0] dead,
                               input bit mid_pulse, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            line_start = (mid_pulse && cyc == 20);
            if (!line_done && !busy) begin
                chk("busy_during_line", {63'd0, busy}, 64'd1);
                break;
            end
            if (line_done) begin
                got = 1'b1;
                lat = cyc + 2;
                break;
            end
        end
        line_start = 1'b0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL line_done_timeout: got no line_done, required one within 3000 cycles");
        end
        chk("timeout_mask", 64'(tmo_mask), 64'(m & dead));
        @(negedge clk);
        chk("line_done_pulse", {62'd0, line_done, busy}, 64'd0);
        @(negedge clk);
        chk("line_done_count", 64'(done_cnt), 64'd1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_line(input logic [NCH-1:0] m, input logic [NCH-1:0] dead,
                            input bit mid_pulse, output int lat);
        start_line(m, dead);
        finish_line(m, dead, mid_pulse, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        bit hit;
        logic [NCH-1:0] m;
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        line_start = 1'b0;
        mask       = '0;
        cur_mask   = '0;
        dead_mask  = '0;
        vre_rand   = 1'b0;
        strict_gap = 1'b0;
        done_cnt   = 0;
        seen       = 1'b0;
        low_run    = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", {23'd0, req, out_valid, busy, line_done, tmo_mask, overrun, 12'd0},
            64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All channels, always ready: 48 words with exact burst spacing.
        strict_gap = 1'b1;
        run_line(12'hFFF, 12'h000, 1'b0, lat);
        strict_gap = 1'b0;
        vre_rand   = 1'b1;

        // Sparse mask.
        run_line(12'b1000_0000_0101, 12'h000, 1'b0, lat);

        // Channel 3 never ready inside a full line.
        run_line(12'hFFF, 12'h008, 1'b0, lat);

        // Timeout length: SEL + 16 WAIT + SEL + DONE.
        run_line(12'h008, 12'h008, 1'b0, lat);
        chk("timeout_latency", 64'(lat), 64'(TMO + 3));

        // Empty mask.
        run_line(12'h000, 12'h000, 1'b0, lat);
        chk("empty_latency", 64'(lat), 64'd2);

        // Random masks with occasional dead channels.
        for (int i = 0; i < 6; i++) begin
            m = NCH'($urandom);
            run_line(m, m & NCH'($urandom) & NCH'($urandom) & NCH'($urandom), 1'b0, lat);
        end

        // line_start while busy.
        chk("overrun_clear", {63'd0, overrun}, 64'd0);
        run_line(12'hFFF, 12'h000, 1'b1, lat);
        chk("overrun_set", {63'd0, overrun}, 64'd1);

        // Reset during a channel 5 burst.
        start_line(12'hFFF, 12'h000);
        hit = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (req[5]) begin
                hit = 1'b1;
                break;
            end
        end
        chk("ch5_reached", {63'd0, hit}, 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {50'd0, req, out_valid, busy}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("reset_held", {51'd0, tmo_mask, overrun}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {62'd0, busy, line_done}, 64'd0);
        run_line(12'hFFF, 12'h000, 1'b0, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
